// File: rtl/sched_medicion_pkg.sv
// Shared types and defaults for the round-robin echo measurement scheduler.
// Optional channel masking is enabled with SCHED_MASK_EN (see sched_medicion).
package sched_pkg;

    typedef enum logic [2:0] {IDLE, TRIG, ARM, MEASURE, GAP} estado_t;

    // Defaults sized for a 50 MHz clock
    localparam int BIT_PERIODO_DEF = 16;
    localparam int TRIG_CYC_DEF    = 500;
    localparam int TIMEOUT_CYC_DEF = 1_900_000;
    localparam int REPOSO_CYC_DEF  = 3_000_000;

    function automatic int calc_cw(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sched_medicion_medidor_pulso.sv
// Pulse-width measurement path: per-channel 2-FF synchronizers, arm logic
// that rejects stale echoes, saturating high-time counter and timeout timer.
module medidor_pulso
    import sched_pkg::*;
#(
    parameter int N_CH        = 2,
    parameter int BIT_periodo = BIT_PERIODO_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    localparam int CW         = calc_cw(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_CH-1:0]        echo,
    input  logic [CW-1:0]          sel,
    input  logic                   start,
    input  logic                   clear,
    output logic                   done,
    output logic                   sube,
    output logic                   timeout,
    output logic [BIT_periodo-1:0] count
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [BIT_periodo-1:0] MAXC = '1;

    typedef enum logic [1:0] {M_IDLE, M_ARM, M_MEAS} fase_t;

    logic [N_CH-1:0]        sync1, sync2;
    fase_t                  fase;
    logic                   seen_low;
    logic [BIT_periodo-1:0] cnt;
    logic [TW-1:0]          tmr;
    logic                   echo_s, tmr_fin;

    assign echo_s  = sync2[sel];
    assign tmr_fin = (tmr == TW'(TIMEOUT_CYC - 1));

    // Priority in MEASURE: echo fall, then saturation, then timeout
    always_comb begin
        done    = 1'b0;
        sube    = 1'b0;
        timeout = 1'b0;
        count   = cnt;
        case (fase)
            M_ARM: begin
                if (tmr_fin) begin
                    done    = 1'b1;
                    timeout = 1'b1;
                    count   = '0;
                end else if (seen_low && echo_s) begin
                    sube = 1'b1;
                end
            end
            M_MEAS: begin
                if (!echo_s) begin
                    done    = 1'b1;
                    timeout = (cnt == MAXC);
                end else if (cnt >= MAXC - 1'b1) begin
                    done    = 1'b1;
                    timeout = 1'b1;
                    count   = MAXC;
                end else if (tmr_fin) begin
                    done    = 1'b1;
                    timeout = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= echo;
            sync2 <= sync1;
        end
        if (rst || clear) begin
            fase     <= M_IDLE;
            seen_low <= 1'b0;
            cnt      <= '0;
            tmr      <= '0;
        end else if (start) begin
            fase     <= M_ARM;
            seen_low <= 1'b0;
            cnt      <= '0;
            tmr      <= '0;
        end else if (fase != M_IDLE) begin
            tmr <= tmr + 1'b1;
            if (done) begin
                fase <= M_IDLE;
            end else if (sube) begin
                fase <= M_MEAS;
                cnt  <= BIT_periodo'(1);
            end else if (fase == M_MEAS) begin
                cnt <= cnt + 1'b1;
            end else if (!echo_s) begin
                seen_low <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/sched_medicion.sv
// Round-robin echo sensor scheduler: trigger, measure, publish, rest, rotate.
// Define SCHED_MASK_EN to add the ch_mask input that skips disabled channels.
module sched_medicion
    import sched_pkg::*;
#(
    parameter int N_CH        = 2,
    parameter int BIT_periodo = BIT_PERIODO_DEF,
    parameter int TRIG_CYC    = TRIG_CYC_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int REPOSO_CYC  = REPOSO_CYC_DEF,
    localparam int CW         = calc_cw(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   run,
    input  logic [N_CH-1:0]        echo,
`ifdef SCHED_MASK_EN
    input  logic [N_CH-1:0]        ch_mask,
`endif
    output logic [N_CH-1:0]        trig,
    output logic [CW-1:0]          ch_act,
    output logic [BIT_periodo-1:0] dato,
    output logic [CW-1:0]          dato_ch,
    output logic                   dato_valid,
    output logic                   timeout,
    output logic                   busy
);

    localparam int TCW = $clog2(TRIG_CYC + 1);
    localparam int GCW = $clog2(REPOSO_CYC + 1);

    estado_t                estado;
    logic [TCW-1:0]         tcnt;
    logic [GCW-1:0]         gcnt;
    logic [N_CH-1:0]        mask;
    logic [CW-1:0]          ch_ini, ch_sig;
    logic                   m_start, m_clear, m_done, m_sube, m_to;
    logic [BIT_periodo-1:0] m_count;

`ifdef SCHED_MASK_EN
    assign mask = ch_mask;
`else
    assign mask = '1;
`endif

    // Nearest enabled channel after cur, wrapping; cur itself is the last resort
    function automatic logic [CW-1:0] siguiente(input logic [CW-1:0] cur,
                                                input logic [N_CH-1:0] m);
        logic [CW-1:0] r;
        int idx;
        r = cur;
        for (int i = N_CH; i >= 1; i--) begin
            idx = (int'(cur) + i) % N_CH;
            if (m[idx]) r = CW'(idx);
        end
        return r;
    endfunction

    function automatic logic [N_CH-1:0] onehot(input logic [CW-1:0] c);
        logic [N_CH-1:0] r;
        r    = '0;
        r[c] = 1'b1;
        return r;
    endfunction

    assign ch_ini  = mask[ch_act] ? ch_act : siguiente(ch_act, mask);
    assign ch_sig  = siguiente(ch_act, mask);
    assign m_start = (estado == TRIG) && (tcnt == TCW'(TRIG_CYC - 1));
    assign m_clear = (estado == IDLE);

    medidor_pulso #(
        .N_CH        (N_CH),
        .BIT_periodo (BIT_periodo),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_medidor (
        .clk     (clk),
        .rst     (rst),
        .echo    (echo),
        .sel     (ch_act),
        .start   (m_start),
        .clear   (m_clear),
        .done    (m_done),
        .sube    (m_sube),
        .timeout (m_to),
        .count   (m_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            estado     <= IDLE;
            trig       <= '0;
            ch_act     <= '0;
            dato       <= '0;
            dato_ch    <= '0;
            dato_valid <= 1'b0;
            timeout    <= 1'b0;
            busy       <= 1'b0;
            tcnt       <= '0;
            gcnt       <= '0;
        end else begin
            dato_valid <= 1'b0;
            case (estado)
                IDLE: begin
                    if (run && |mask) begin
                        estado <= TRIG;
                        ch_act <= ch_ini;
                        trig   <= onehot(ch_ini);
                        tcnt   <= '0;
                        busy   <= 1'b1;
                    end
                end
                TRIG: begin
                    tcnt <= tcnt + 1'b1;
                    if (m_start) begin
                        trig   <= '0;
                        estado <= ARM;
                    end
                end
                ARM, MEASURE: begin
                    if (m_done) begin
                        dato       <= m_count;
                        dato_ch    <= ch_act;
                        timeout    <= m_to;
                        dato_valid <= 1'b1;
                        gcnt       <= '0;
                        estado     <= GAP;
                    end else if (m_sube) begin
                        estado <= MEASURE;
                    end
                end
                GAP: begin
                    gcnt <= gcnt + 1'b1;
                    if (gcnt == GCW'(REPOSO_CYC - 1)) begin
                        ch_act <= ch_sig;
                        if (run && |mask) begin
                            estado <= TRIG;
                            trig   <= onehot(ch_sig);
                            tcnt   <= '0;
                        end else begin
                            estado <= IDLE;
                            busy   <= 1'b0;
                        end
                    end
                end
                default: estado <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sched_medicion.sv
// Directed bench for sched_medicion: two instances differing only in timeout length.
module tb_sched_medicion;

    logic       clk = 1'b0;
    logic       rst, run, run_b;
    logic [1:0] echo, echo_b;
    logic [1:0] trig, trig_b;
    logic       ch_act, ch_act_b, dato_ch, dato_ch_b;
    logic [7:0] dato, dato_b;
    logic       dato_valid, dato_valid_b, timeout, timeout_b, busy, busy_b;
`ifdef SCHED_MASK_EN
    logic [1:0] ch_mask = 2'b11;
    logic [1:0] ch_mask_b = 2'b11;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sched_medicion #(.N_CH(2), .BIT_periodo(8), .TRIG_CYC(4), .TIMEOUT_CYC(50), .REPOSO_CYC(10)) dut (
        .clk(clk), .rst(rst), .run(run), .echo(echo),
`ifdef SCHED_MASK_EN
        .ch_mask(ch_mask),
`endif
        .trig(trig), .ch_act(ch_act), .dato(dato), .dato_ch(dato_ch),
        .dato_valid(dato_valid), .timeout(timeout), .busy(busy)
    );

    sched_medicion #(.N_CH(2), .BIT_periodo(8), .TRIG_CYC(4), .TIMEOUT_CYC(400), .REPOSO_CYC(10)) dut_b (
        .clk(clk), .rst(rst), .run(run_b), .echo(echo_b),
`ifdef SCHED_MASK_EN
        .ch_mask(ch_mask_b),
`endif
        .trig(trig_b), .ch_act(ch_act_b), .dato(dato_b), .dato_ch(dato_ch_b),
        .dato_valid(dato_valid_b), .timeout(timeout_b), .busy(busy_b)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // k = negedges until trig[ch] equals lvl, -1 if the bound expires
    task automatic wait_trig(input bit b, input int ch, input logic lvl, input int max, output int k);
        k = -1;
        for (int i = 1; i <= max; i++) begin
            @(negedge clk);
            if ((b ? trig_b[ch] : trig[ch]) === lvl) begin k = i; break; end
        end
    endtask

    task automatic wait_valid(input bit b, input int max, output int k);
        k = -1;
        for (int i = 1; i <= max; i++) begin
            @(negedge clk);
            if ((b ? dato_valid_b : dato_valid) === 1'b1) begin k = i; break; end
        end
    endtask

    task automatic wait_idle(input int max, output int k);
        k = -1;
        for (int i = 1; i <= max; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin k = i; break; end
        end
    endtask

    task automatic pulse_echo(input int ch, input int pre, input int len);
        tick(pre);
        echo[ch] = 1'b1;
        tick(len);
        echo[ch] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; run = 1'b0; run_b = 1'b0; echo = '0; echo_b = '0;
        tick(3);
        n_cmp++; if (trig !== 2'b00)     begin n_err++; $display("FAIL reset_trig: got %b want 00", trig); end
        n_cmp++; if (ch_act !== 1'b0)    begin n_err++; $display("FAIL reset_ch_act: got %b want 0", ch_act); end
        n_cmp++; if (dato !== 8'd0)      begin n_err++; $display("FAIL reset_dato: got %0d want 0", dato); end
        n_cmp++; if (dato_ch !== 1'b0)   begin n_err++; $display("FAIL reset_dato_ch: got %b want 0", dato_ch); end
        n_cmp++; if (dato_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", dato_valid); end
        n_cmp++; if (timeout !== 1'b0)   begin n_err++; $display("FAIL reset_timeout: got %b want 0", timeout); end
        n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (trig_b !== 2'b00)   begin n_err++; $display("FAIL reset_trig_b: got %b want 00", trig_b); end
        rst = 1'b0;
        tick(3);
        n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL idle_no_run_busy: got %b want 0", busy); end
    endtask

    task automatic test_basic();
        int k, cnt;
        run = 1'b1;
        wait_trig(0, 0, 1'b1, 5, k);
        n_cmp++; if (k !== 1)         begin n_err++; $display("FAIL basic_start_latency: got %0d want 1", k); end
        n_cmp++; if (trig !== 2'b01)  begin n_err++; $display("FAIL basic_trig_onehot: got %b want 01", trig); end
        n_cmp++; if (busy !== 1'b1)   begin n_err++; $display("FAIL basic_busy: got %b want 1", busy); end
        cnt = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (trig[0]) cnt++; else break;
        end
        n_cmp++; if (cnt !== 4)       begin n_err++; $display("FAIL basic_trig_len: got %0d want 4", cnt); end
        pulse_echo(0, 2, 20);
        wait_valid(0, 10, k);
        n_cmp++; if (k !== 3)         begin n_err++; $display("FAIL basic_valid_latency: got %0d want 3", k); end
        n_cmp++; if (dato !== 8'd20)  begin n_err++; $display("FAIL basic_dato: got %0d want 20", dato); end
        n_cmp++; if (dato_ch !== 1'b0) begin n_err++; $display("FAIL basic_dato_ch: got %0d want 0", dato_ch); end
        n_cmp++; if (timeout !== 1'b0) begin n_err++; $display("FAIL basic_timeout: got %b want 0", timeout); end
        tick(1);
        n_cmp++; if (dato_valid !== 1'b0) begin n_err++; $display("FAIL basic_valid_pulse: got %b want 0", dato_valid); end
    endtask

    task automatic test_rotation();
        int k;
        wait_trig(0, 1, 1'b1, 20, k);
        n_cmp++; if (k !== 9)         begin n_err++; $display("FAIL rot_gap_len: got %0d want 9", k); end
        n_cmp++; if (ch_act !== 1'b1) begin n_err++; $display("FAIL rot_ch_act: got %0d want 1", ch_act); end
        wait_trig(0, 1, 1'b0, 10, k);
        n_cmp++; if (k !== 4)         begin n_err++; $display("FAIL rot_trig_len: got %0d want 4", k); end
        pulse_echo(1, 2, 7);
        wait_valid(0, 10, k);
        n_cmp++; if (k !== 3)         begin n_err++; $display("FAIL rot_valid_latency: got %0d want 3", k); end
        n_cmp++; if (dato !== 8'd7)   begin n_err++; $display("FAIL rot_dato: got %0d want 7", dato); end
        n_cmp++; if (dato_ch !== 1'b1) begin n_err++; $display("FAIL rot_dato_ch: got %0d want 1", dato_ch); end
        wait_trig(0, 0, 1'b1, 20, k);
        n_cmp++; if (ch_act !== 1'b0 || k < 0) begin n_err++; $display("FAIL rot_wrap: got ch %0d wait %0d want ch 0", ch_act, k); end
    endtask

    task automatic test_no_echo();
        int k;
        wait_trig(0, 0, 1'b0, 10, k);
        wait_valid(0, 60, k);
        n_cmp++; if (k !== 50)        begin n_err++; $display("FAIL noecho_latency: got %0d want 50", k); end
        n_cmp++; if (dato !== 8'd0)   begin n_err++; $display("FAIL noecho_dato: got %0d want 0", dato); end
        n_cmp++; if (timeout !== 1'b1) begin n_err++; $display("FAIL noecho_timeout: got %b want 1", timeout); end
    endtask

    task automatic test_stuck_run_drop();
        int k, hi;
        echo[1] = 1'b1;
        wait_trig(0, 1, 1'b1, 20, k);
        n_cmp++; if (k !== 10)        begin n_err++; $display("FAIL stuck_gap_len: got %0d want 10", k); end
        run = 1'b0;
        wait_trig(0, 1, 1'b0, 10, k);
        wait_valid(0, 60, k);
        n_cmp++; if (k !== 50)        begin n_err++; $display("FAIL stuck_latency: got %0d want 50", k); end
        n_cmp++; if (dato !== 8'd0 || timeout !== 1'b1 || dato_ch !== 1'b1)
            begin n_err++; $display("FAIL stuck_result: got %0d/%b/%0d want 0/1/1", dato, timeout, dato_ch); end
        echo[1] = 1'b0;
        wait_idle(20, k);
        n_cmp++; if (k !== 10)        begin n_err++; $display("FAIL drop_idle: got %0d want 10", k); end
        n_cmp++; if (ch_act !== 1'b0) begin n_err++; $display("FAIL drop_ch_act: got %0d want 0", ch_act); end
        hi = 0;
        for (int i = 0; i < 15; i++) begin @(negedge clk); if (trig !== 2'b00) hi++; end
        n_cmp++; if (hi !== 0)        begin n_err++; $display("FAIL drop_no_trig: got %0d want 0", hi); end
    endtask

    task automatic test_timeout_edge();
        int k;
        run = 1'b1;
        wait_trig(0, 0, 1'b1, 5, k);
        wait_trig(0, 0, 1'b0, 10, k);
        pulse_echo(0, 2, 45);
        wait_valid(0, 10, k);
        n_cmp++; if (k !== 3)         begin n_err++; $display("FAIL edge_fall_latency: got %0d want 3", k); end
        n_cmp++; if (dato !== 8'd45 || timeout !== 1'b0)
            begin n_err++; $display("FAIL edge_fall_wins: got %0d/%b want 45/0", dato, timeout); end
        wait_trig(0, 1, 1'b1, 20, k);
        run = 1'b0;
        wait_trig(0, 1, 1'b0, 10, k);
        pulse_echo(1, 2, 46);
        wait_valid(0, 10, k);
        n_cmp++; if (k !== 2)         begin n_err++; $display("FAIL edge_late_latency: got %0d want 2", k); end
        n_cmp++; if (dato !== 8'd45 || timeout !== 1'b1 || dato_ch !== 1'b1)
            begin n_err++; $display("FAIL edge_late_timeout: got %0d/%b/%0d want 45/1/1", dato, timeout, dato_ch); end
        wait_idle(20, k);
    endtask

    task automatic test_saturation();
        int k;
        run_b = 1'b1;
        wait_trig(1, 0, 1'b1, 5, k);
        wait_trig(1, 0, 1'b0, 10, k);
        tick(2);
        echo_b[0] = 1'b1;
        wait_valid(1, 300, k);
        n_cmp++; if (k !== 257)         begin n_err++; $display("FAIL sat_latency: got %0d want 257", k); end
        n_cmp++; if (dato_b !== 8'd255) begin n_err++; $display("FAIL sat_dato: got %0d want 255", dato_b); end
        n_cmp++; if (timeout_b !== 1'b1) begin n_err++; $display("FAIL sat_timeout: got %b want 1", timeout_b); end
        run_b = 1'b0;
        tick(43);
        echo_b[0] = 1'b0;
        tick(5);
    endtask

    task automatic test_reset_mid();
        int k, nv;
        run = 1'b1;
        wait_trig(0, 0, 1'b1, 5, k);
        wait_trig(0, 0, 1'b0, 10, k);
        tick(2);
        echo[0] = 1'b1;
        tick(6);
        rst = 1'b1;
        tick(1);
        n_cmp++; if (trig !== 2'b00 || busy !== 1'b0)
            begin n_err++; $display("FAIL rstmid_trig_busy: got %b/%b want 00/0", trig, busy); end
        n_cmp++; if (dato !== 8'd0 || dato_ch !== 1'b0 || timeout !== 1'b0 || dato_valid !== 1'b0 || ch_act !== 1'b0)
            begin n_err++; $display("FAIL rstmid_outputs: got %0d/%0d/%b/%b/%0d want 0/0/0/0/0", dato, dato_ch, timeout, dato_valid, ch_act); end
        run = 1'b0;
        echo[0] = 1'b0;
        tick(1);
        rst = 1'b0;
        nv = 0;
        for (int i = 0; i < 60; i++) begin @(negedge clk); if (dato_valid) nv++; end
        n_cmp++; if (nv !== 0)        begin n_err++; $display("FAIL rstmid_no_valid: got %0d want 0", nv); end
    endtask

`ifdef SCHED_MASK_EN
    task automatic test_mask();
        int k, t0, r1;
        logic prev;
        ch_mask = 2'b10;
        run = 1'b1;
        wait_trig(0, 1, 1'b1, 5, k);
        n_cmp++; if (k !== 1 || ch_act !== 1'b1)
            begin n_err++; $display("FAIL mask_first: got wait %0d ch %0d want 1/1", k, ch_act); end
        t0 = 0; r1 = 0; prev = trig[1];
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (trig[0]) t0++;
            if (trig[1] && !prev) r1++;
            prev = trig[1];
        end
        n_cmp++; if (t0 !== 0)        begin n_err++; $display("FAIL mask_ch0_trig: got %0d want 0", t0); end
        n_cmp++; if (r1 < 2)          begin n_err++; $display("FAIL mask_ch1_rounds: got %0d want >=2", r1); end
        ch_mask = 2'b00;
        wait_idle(100, k);
        n_cmp++; if (k < 0)           begin n_err++; $display("FAIL mask_all_idle: got busy %b want 0", busy); end
        t0 = 0;
        for (int i = 0; i < 20; i++) begin @(negedge clk); if (trig !== 2'b00 || busy) t0++; end
        n_cmp++; if (t0 !== 0)        begin n_err++; $display("FAIL mask_all_stay: got %0d want 0", t0); end
        run = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_rotation();
        test_no_echo();
        test_stuck_run_drop();
        test_timeout_edge();
        test_saturation();
        test_reset_mid();
`ifdef SCHED_MASK_EN
        test_mask();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish within bound");
        $fatal(1);
    end

endmodule
